// File: rtl/adder_tree_seq.sv
// Packs a neuron's operand stream into N_OPS-lane groups for the adder tree and accumulates a saturating sign-magnitude total.
// Latency: result valid 1 + L + ceil(L/N_OPS) cycles after start (1 cycle for len=0).
// Backpressure: in_valid low stalls FILL; out_data/sat are held in DONE until out_ready.
module adder_tree_seq #(
    parameter int N_OPS = 8,
    parameter int WIDTH = 16,
    parameter int FRAC  = 10,
    parameter int LEN_W = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [LEN_W-1:0]         len,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic [N_OPS*WIDTH-1:0]   tree_operand,
    input  logic [WIDTH-1:0]         tree_sum,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     sat,
    output logic                     busy
);

    localparam int IDX_W = (N_OPS > 1) ? $clog2(N_OPS) : 1;
    localparam int MAG_W = WIDTH - 1;
    localparam logic [MAG_W-1:0] MAG_MAX = {MAG_W{1'b1}};

    if (FRAC < 0 || FRAC >= WIDTH || N_OPS < 1) begin : g_bad_param
        $error("adder_tree_seq: FRAC must lie in [0, WIDTH) and N_OPS must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        SUM  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [LEN_W-1:0]   remaining;
    logic [WIDTH-1:0]   acc;
    logic               fill_hs;
    logic               last_lane;
    logic               last_op;

    logic [MAG_W-1:0]   a_mag;
    logic [MAG_W-1:0]   b_mag;
    logic               a_neg;
    logic               b_neg;
    logic [MAG_W:0]     mag_sum;
    logic [WIDTH-1:0]   add_res;
    logic               add_ovf;

    assign out_data  = acc;
    assign fill_hs   = (state == FILL) && in_valid;
    assign last_lane = (idx == IDX_W'(N_OPS - 1));
    assign last_op   = (remaining == LEN_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len != '0) ? FILL : DONE;
                end
            end
            FILL: begin
                in_ready = 1'b1;
                if (in_valid && (last_lane || last_op)) begin
                    state_nxt = SUM;
                end
            end
            SUM: begin
                state_nxt = (remaining == '0) ? DONE : FILL;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Negative zero on either side is folded to +0 before the sign compare.
    always_comb begin
        a_mag   = acc[MAG_W-1:0];
        b_mag   = tree_sum[MAG_W-1:0];
        a_neg   = acc[WIDTH-1] && (a_mag != '0);
        b_neg   = tree_sum[WIDTH-1] && (b_mag != '0);
        mag_sum = {1'b0, a_mag} + {1'b0, b_mag};
        add_res = '0;
        add_ovf = 1'b0;
        if (a_neg == b_neg) begin
            if (mag_sum[MAG_W]) begin
                add_res = {a_neg, MAG_MAX};
                add_ovf = 1'b1;
            end else begin
                add_res = {a_neg, mag_sum[MAG_W-1:0]};
            end
        end else if (a_mag > b_mag) begin
            add_res = {a_neg, a_mag - b_mag};
        end else if (b_mag > a_mag) begin
            add_res = {b_neg, b_mag - a_mag};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tree_operand <= '0;
            acc          <= '0;
            idx          <= '0;
            remaining    <= '0;
            sat          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        tree_operand <= '0;
                        acc          <= '0;
                        idx          <= '0;
                        remaining    <= len;
                        sat          <= 1'b0;
                    end
                end
                FILL: begin
                    if (fill_hs) begin
                        for (int k = 0; k < N_OPS; k++) begin
                            if (idx == IDX_W'(k)) begin
                                tree_operand[k*WIDTH +: WIDTH] <= in_data;
                            end
                        end
                        idx       <= idx + IDX_W'(1);
                        remaining <= remaining - LEN_W'(1);
                    end
                end
                SUM: begin
                    acc          <= add_res;
                    tree_operand <= '0;
                    idx          <= '0;
                    if (add_ovf) begin
                        sat <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_tree_seq.sv
// Directed-vector bench for adder_tree_seq with a behavioural exact-sum adder tree.
module tb_adder_tree_seq;

    localparam int N_OPS = 8;
    localparam int WIDTH = 16;
    localparam int LEN_W = 10;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic [LEN_W-1:0]       len;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_data;
    logic [N_OPS*WIDTH-1:0] tree_operand;
    logic [WIDTH-1:0]       tree_sum;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic                   sat;
    logic                   busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int sum_cnt = 0;
    logic [127:0] sum_bus;
    logic [15:0] ops [16];

    adder_tree_seq #(.N_OPS(N_OPS), .WIDTH(WIDTH), .FRAC(10), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .tree_operand(tree_operand), .tree_sum(tree_sum),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sat(sat), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Exact tree sum; a zero total containing a negative lane comes back as negative zero.
    int         t_s;
    logic       t_neg;
    logic [15:0] t_lane;
    always_comb begin
        t_s = 0;
        t_neg = 1'b0;
        t_lane = '0;
        tree_sum = '0;
        for (int k = 0; k < N_OPS; k++) begin
            t_lane = tree_operand[k*WIDTH +: WIDTH];
            if (t_lane[15]) begin
                t_s = t_s - int'(t_lane[14:0]);
                t_neg = 1'b1;
            end else begin
                t_s = t_s + int'(t_lane[14:0]);
            end
        end
        if (t_s < 0)
            tree_sum = {1'b1, 15'(-t_s)};
        else if (t_s == 0 && t_neg)
            tree_sum = 16'h8000;
        else
            tree_sum = {1'b0, 15'(t_s)};
    end

    always @(negedge clk) begin
        if (!rst && busy && !in_ready && !out_valid) begin
            if (sum_cnt == 0) sum_bus = tree_operand;
            sum_cnt = sum_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic feed(input string tag, input int n, input int gap, input int hold,
                        input logic [15:0] exp_data, input logic exp_sat,
                        input int exp_lat, input int exp_sums);
        int t0;
        int b;
        @(posedge clk); #1;
        sum_cnt = 0;
        start = 1'b1;
        len = n[LEN_W-1:0];
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1;
            in_data = ops[i];
            b = 0;
            while (!in_ready && b < 50) begin
                @(posedge clk); #1;
                b++;
            end
            chk({tag, "_rdy"}, in_ready, 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        b = 0;
        while (!out_valid && b < 100) begin
            @(posedge clk); #1;
            b++;
        end
        chk({tag, "_vld"}, out_valid, 1);
        if (exp_lat >= 0) chk({tag, "_lat"}, cyc - t0, exp_lat);
        chk({tag, "_data"}, out_data, exp_data);
        chk({tag, "_sat"}, sat, exp_sat);
        chk({tag, "_sums"}, sum_cnt, exp_sums);
        for (int h = 0; h < hold; h++) begin
            start = (h == 2);
            len = 10'd5;
            @(posedge clk); #1;
            chk({tag, "_hold_vld"}, out_valid, 1);
            chk({tag, "_hold_data"}, out_data, exp_data);
            chk({tag, "_hold_rdy"}, in_ready, 0);
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_vld"}, out_valid, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        len = '0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_rdy", in_ready, 0);
        chk("rst_vld", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_sat", sat, 0);
        chk("rst_bus", tree_operand, 0);
        rst = 1'b0;

        ops[0] = 16'h020A; ops[1] = 16'h0040; ops[2] = 16'h801B; ops[3] = 16'h81CC;
        ops[4] = 16'h83E1; ops[5] = 16'h04D7; ops[6] = 16'h0031; ops[7] = 16'h007A;
        feed("t1", 8, 0, 0, 16'h0204, 1'b0, 10, 1);
        chk("t1_bus", sum_bus, 128'h007A_0031_04D7_83E1_81CC_801B_0040_020A);

        ops[0] = 16'h0400; ops[1] = 16'h0400; ops[2] = 16'h8200;
        feed("t2", 3, 0, 0, 16'h0600, 1'b0, 5, 1);
        chk("t2_bus", sum_bus, 128'h0000_0000_0000_0000_0000_8200_0400_0400);

        for (int i = 0; i < 8; i++) ops[i] = 16'h0800;
        ops[8] = 16'h2000; ops[9] = 16'h2000;
        feed("t3", 10, 0, 0, 16'h7FFF, 1'b1, 13, 2);

        for (int i = 0; i < 8; i++) ops[i] = 16'h0010;
        ops[8] = 16'h8200;
        feed("x1", 9, 0, 0, 16'h8180, 1'b0, 12, 2);

        for (int i = 0; i < 8; i++) ops[i] = 16'h0020;
        ops[8] = 16'h8100;
        feed("x2", 9, 0, 0, 16'h0000, 1'b0, 12, 2);

        ops[0] = 16'h0123; ops[1] = 16'h8123;
        feed("t4a", 2, 0, 0, 16'h0000, 1'b0, 4, 1);
        ops[0] = 16'h8000;
        feed("t4b", 1, 0, 0, 16'h0000, 1'b0, 3, 1);

        ops[0] = 16'h0001; ops[1] = 16'h0002; ops[2] = 16'h0003; ops[3] = 16'h0004;
        feed("t5", 4, 2, 5, 16'h000A, 1'b0, -1, 1);

        feed("t6z", 0, 0, 0, 16'h0000, 1'b0, 1, 0);

        @(posedge clk); #1;
        start = 1'b1;
        len = 10'd8;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data = 16'h0111;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6r_busy", busy, 0);
        chk("t6r_bus", tree_operand, 0);
        chk("t6r_vld", out_valid, 0);
        chk("t6r_data", out_data, 0);

        ops[0] = 16'h0100; ops[1] = 16'h0100;
        feed("t6f", 2, 0, 0, 16'h0200, 1'b0, 4, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
